sll_seq_32: RTL and testbench

- Multi-cycle logical left shifter; the left-direction counterpart of the combinational logical right shifter.
- Resolves one shamt bit per clock, LSB first: stage k shifts by 2^k when shamt[k]=1. Total shift is 1,2,4,8,16 over 5 stages.
- Used by the multi-cycle datapath for SLL/SLLV. It frees the ALU from a full 32-bit barrel and exposes a start/busy/done handshake to the control FSM.

---
 rtl/sll_seq_32.sv | 120 ++++++++++++
 tb/tb_sll_seq_32.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sll_seq_32.sv
// sll_seq_32: multi-cycle logical left shifter, one shamt bit resolved per clock, LSB first.
// Optional SLL_SEQ_EARLY_DONE_EN: finish as soon as no higher shamt bits remain set.
module sll_seq_32 #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   rt,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   rd
);

  localparam int STEP_W = $clog2(SHAMT_W + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] sh_q, sh_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] stage_amt;
  logic [WIDTH-1:0]   acc_shift;
  logic [WIDTH-1:0]   acc_next;
  logic               last_step;
  logic               finish;

  // Stage k contributes a shift of 2^k when the matching shamt bit is set.
  always_comb begin
    stage_amt         = '0;
    stage_amt[step_q] = 1'b1;
    acc_shift         = acc_q << stage_amt;
    acc_next          = sh_q[step_q] ? acc_shift : acc_q;
  end

  always_comb begin
    last_step = (step_q == STEP_W'(SHAMT_W - 1));
`ifdef SLL_SEQ_EARLY_DONE_EN
    finish = (state_q == S_BUSY) &&
             (last_step || (((sh_q >> step_q) >> 1) == '0));
`else
    finish = (state_q == S_BUSY) && last_step;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_BUSY;
      S_BUSY: if (finish) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    step_d = step_q;
    rd_d   = rd_q;
    done_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        acc_d  = rt;
        sh_d   = shamt;
        step_d = '0;
      end
    end else begin
      acc_d  = acc_next;
      step_d = step_q + STEP_W'(1);
      if (finish) begin
        rd_d   = acc_next;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      sh_q   <= '0;
      step_q <= '0;
      rd_q   <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      step_q <= step_d;
      rd_q   <= rd_d;
      done_q <= done_d;
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_BUSY);
    done = done_q;
    rd   = rd_q;
  end

endmodule

// File: tb/tb_sll_seq_32.sv
// Bench for sll_seq_32: behavioural model (shift result + latency countdown) checked every cycle,
// plus directed cases with hand-computed results and latencies.
module tb_sll_seq_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] rt;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dcnt = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_res = '0;
  int          m_cnt = 0;

  sll_seq_32 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rt    (rt),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  // Number of clock edges after the accepting edge until the completing edge.
  function automatic int exp_lat(input logic [4:0] sh);
`ifdef SLL_SEQ_EARLY_DONE_EN
    int k = 0;
    for (int i = 0; i < 5; i++) if (sh[i]) k = i;
    return k + 1;
`else
    return 5;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (done === 1'b1) dcnt++;
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_rd   = '0;
      m_cnt  = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_rd   = m_res;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_res  = 32'((64'(rt)) << shamt);
        m_cnt  = exp_lat(shamt);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("done", {31'b0, done}, {31'b0, m_done});
      check("rd", rd, m_rd);
    end
  end

  task automatic launch(input logic [31:0] a, input logic [4:0] sh, output int s);
    start = 1'b1;
    rt    = a;
    shamt = sh;
    s     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    rt    = $urandom;
    shamt = 5'($urandom);
  endtask

  task automatic wait_done(output int e);
    int n = 0;
    e = -1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done === 1'b1) e = cyc;
    else check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [4:0] sh,
                        input logic [31:0] exp_rd);
    int s, e;
    launch(a, sh, s);
    wait_done(e);
    check({name, "_rd"}, rd, exp_rd);
    check({name, "_lat"}, 32'(e - s), 32'(exp_lat(sh)));
  endtask

  initial begin
    int s, e, c0;
    rst   = 1'b1;
    start = 1'b1;
    rt    = $urandom;
    shamt = 5'($urandom);
    @(negedge clk);
    rt = $urandom;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_rd", rd, 32'h0000_0000);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_nostart", {31'b0, busy}, 32'd0);

    // Directed cases, each launched in the done cycle of the previous one
    run_op("sh31", 32'h0000_0001, 5'd31, 32'h8000_0000);
    run_op("ones4", 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0);
    run_op("b2b0", 32'h1234_5678, 5'd0, 32'h1234_5678);
    run_op("early2", 32'h0000_0003, 5'd2, 32'h0000_000C);
    run_op("early0", 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D);
    @(negedge clk);

    // Start while busy must be ignored
    c0 = dcnt;
    launch(32'h0000_000F, 5'd8, s);
    @(negedge clk);
    start = 1'b1;
    rt    = 32'hDEAD_BEEF;
    shamt = 5'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(e);
    check("prot_rd", rd, 32'h0000_0F00);
    check("prot_lat", 32'(e - s), 32'(exp_lat(5'd8)));
    repeat (10) @(negedge clk);
    check("prot_dones", 32'(dcnt - c0), 32'd1);
    check("prot_hold_rd", rd, 32'h0000_0F00);

    // Reset in the middle of an operation
    c0 = dcnt;
    launch(32'hAAAA_AAAA, 5'd1, s);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rd", rd, 32'h0000_0000);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    check("midrst_dones", 32'(dcnt - c0), (exp_lat(5'd1) < 3) ? 32'd1 : 32'd0);

    // Randomized traffic: start/rt/shamt toggling freely, occasional resets
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) != 0);
      rt    = $urandom;
      shamt = 5'($urandom);
      rst   = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
